// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the unified pipeline hazard controller:
// FSM state codes, EX operand mux select encodings and window counter width.
package pipe_hazard_ctrl_pkg;

    // Controller modes: normal issue, multi-cycle load bubble, branch flush window.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // EX operand mux selects.
    localparam logic [1:0] FWD_REG = 2'b00;   // register file value
    localparam logic [1:0] FWD_MEM = 2'b10;   // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b01;   // MEM/WB write data

    // Width of the stall/flush window down-counter (covers latencies up to 7).
    localparam int WIN_W = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One EX operand forwarding comparator. The EX/MEM producer is younger than the
// MEM/WB producer, so it wins when both target the same register.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic mem_hit_s;
    logic wb_hit_s;

    // Register 0 is hardwired zero, so a write to it never produces a value to forward.
    always_comb begin
        mem_hit_s = mem_regwrite & (mem_rd != REG_ZERO) & (mem_rd == src);
        wb_hit_s  = wb_regwrite  & (wb_rd  != REG_ZERO) & (wb_rd  == src);
    end

    // Pick the newest producer; without forwarding the operand always comes from the register file.
    always_comb begin
        sel = FWD_REG;
        if (FWD_EN == 0) begin
            sel = FWD_REG;
        end else if (mem_hit_s) begin
            sel = FWD_MEM;
        end else if (wb_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Unified hazard controller for the 5-stage MIPS pipeline: EX operand forwarding
// selects, load-use / RAW stalls, branch/jump flush windows and saturating
// stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    input  logic              br_taken_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [REG_AW-1:0] REG_ZERO    = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [WIN_W-1:0]  WIN_ZERO    = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]  WIN_ONE     = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]  LOAD_RELOAD = WIN_W'(LOAD_LAT - 1);
    localparam logic [WIN_W-1:0]  BR_RELOAD   = WIN_W'(BR_FLUSH - 1);

    state_e            state_r;
    state_e            state_nx_s;
    logic [WIN_W-1:0]  cnt_r;
    logic [WIN_W-1:0]  cnt_nx_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;
    logic              rs_ex_hit_s;
    logic              rt_ex_hit_s;
    logic              mem_src_hit_s;
    logic              load_use_s;
    logic              raw_s;
    logic              stall_s;
    logic              flush_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .src          (ex_rs_i),
        .mem_rd       (mem_rd_i),
        .mem_regwrite (mem_regwrite_i),
        .wb_rd        (wb_rd_i),
        .wb_regwrite  (wb_regwrite_i),
        .sel          (fwd_a_s)
    );

    pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .src          (ex_rt_i),
        .mem_rd       (mem_rd_i),
        .mem_regwrite (mem_regwrite_i),
        .wb_rd        (wb_rd_i),
        .wb_regwrite  (wb_regwrite_i),
        .sel          (fwd_b_s)
    );

    // Detect whether the ID instruction reads a register still being produced further down the pipe.
    always_comb begin
        rs_ex_hit_s   = id_rs_used_i & (ex_rd_i != REG_ZERO) & (id_rs_i == ex_rd_i);
        rt_ex_hit_s   = id_rt_used_i & (ex_rd_i != REG_ZERO) & (id_rt_i == ex_rd_i);
        mem_src_hit_s = mem_regwrite_i & (mem_rd_i != REG_ZERO) &
                        ((id_rs_used_i & (id_rs_i == mem_rd_i)) |
                         (id_rt_used_i & (id_rt_i == mem_rd_i)));
        load_use_s    = ex_memread_i & (rs_ex_hit_s | rt_ex_hit_s);
        if (FWD_EN == 0) begin
            // Without bypass paths any pending EX or MEM writer must reach writeback first.
            raw_s = (ex_regwrite_i & (rs_ex_hit_s | rt_ex_hit_s)) | mem_src_hit_s;
        end else begin
            raw_s = 1'b0;
        end
    end

    // Next-state logic: a taken branch overrides everything, then open windows run out, then new hazards.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        stall_s    = 1'b0;
        flush_s    = 1'b0;
        if (br_taken_i) begin
            flush_s = 1'b1;
            if (BR_FLUSH > 1) begin
                state_nx_s = ST_FLUSH;
                cnt_nx_s   = BR_RELOAD;
            end else begin
                state_nx_s = ST_RUN;
                cnt_nx_s   = WIN_ZERO;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_use_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nx_s = ST_STALL;
                            cnt_nx_s   = LOAD_RELOAD;
                        end else begin
                            state_nx_s = ST_RUN;
                        end
                    end else if (raw_s) begin
                        // Re-evaluated every cycle; the stall lifts when the writer retires.
                        stall_s = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                ST_STALL: begin
                    stall_s = 1'b1;
                    if (cnt_r == WIN_ONE) begin
                        state_nx_s = ST_RUN;
                        cnt_nx_s   = WIN_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r - WIN_ONE;
                    end
                end
                ST_FLUSH: begin
                    flush_s = 1'b1;
                    if (cnt_r == WIN_ONE) begin
                        state_nx_s = ST_RUN;
                        cnt_nx_s   = WIN_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r - WIN_ONE;
                    end
                end
                default: begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = WIN_ZERO;
                end
            endcase
        end
    end

    // State and window counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            cnt_r   <= WIN_ZERO;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Saturating performance counters; a branch cycle never counts as a stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (br_taken_i && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Pipeline controls; held at their idle values while reset is asserted so a reset
    // landing mid-window takes effect in the same cycle.
    always_comb begin
        if (rst_i) begin
            fwd_a_o       = FWD_REG;
            fwd_b_o       = FWD_REG;
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
        end else begin
            fwd_a_o       = fwd_a_s;
            fwd_b_o       = fwd_b_s;
            pc_write_o    = ~stall_s;
            ifid_write_o  = ~stall_s;
            ifid_flush_o  = flush_s;
            idex_bubble_o = stall_s | br_taken_i;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;

endmodule
